// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/compare/shift ops and a
// WIDTH-cycle shift-add unsigned multiplier, with registered result and flags.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       F,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_IT  = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_GT   = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   y_reg, y_next;
  logic [WIDTH-1:0]   yhi_reg, yhi_next;
  logic               zero_reg, zero_next;
  logic               carry_reg, carry_next;
  logic               ovf_reg, ovf_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [CW-1:0]      cnt_reg, cnt_next;

  logic [WIDTH-1:0]   b_inv;
  logic [WIDTH:0]     add_sum, sub_sum, mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_inv[gi] = ~B[gi];
    end
  endgenerate

  // Subtraction shares the adder form A + ~B + 1 so carry=1 means no borrow.
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (F)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_GT:   alu_res[0] = (A > B);
      OP_ANDN: alu_res = A & b_inv;
      OP_ORN:  alu_res = A | b_inv;
      OP_SUB: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_EQ:   alu_res[0] = (A == B);
      OP_SHL:  if (B < W_VAL) alu_res = A << B;
      OP_SHR:  if (B < W_VAL) alu_res = A >> B;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: the multiplier sits in the low half and drains out as the
  // partial product shifts in from the top.
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
  assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    yhi_next   = yhi_reg;
    zero_next  = zero_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;
    prod_next  = prod_reg;
    mcand_next = mcand_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      EXEC: begin
        prod_next = prod_step;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IT) begin
          y_next     = prod_step[WIDTH-1:0];
          yhi_next   = prod_step[2*WIDTH-1:WIDTH];
          zero_next  = (prod_step == '0);
          carry_next = 1'b0;
          ovf_next   = 1'b0;
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
        if (start) begin
          if (F == OP_MUL) begin
            mcand_next = A;
            prod_next  = {{WIDTH{1'b0}}, B};
            cnt_next   = '0;
            state_next = EXEC;
          end else begin
            y_next     = alu_res;
            yhi_next   = '0;
            zero_next  = (alu_res == '0);
            carry_next = alu_carry;
            ovf_next   = alu_ovf;
            state_next = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      yhi_reg   <= '0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      yhi_reg   <= yhi_next;
      zero_reg  <= zero_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
      prod_reg  <= prod_next;
      mcand_reg <= mcand_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Y     = y_reg;
  assign Y_hi  = yhi_reg;
  assign zero  = zero_reg;
  assign carry = carry_reg;
  assign ovf   = ovf_reg;
  assign busy  = (state_reg == EXEC);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): hand-computed vectors checked with
// immediate assertions after each accepting edge.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic [3:0] F;
  logic [7:0] Y, Y_hi;
  logic       busy, done, zero, carry, ovf;

  int n_asserts = 0;
  int n_fail    = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .F(F),
    .Y(Y), .Y_hi(Y_hi), .busy(busy), .done(done),
    .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op at the falling edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    @(negedge clk);
    A = a; B = b; F = f; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic show(input string name);
    $display("%s: A=%h B=%h F=%h -> Y=%h Y_hi=%h zero=%b carry=%b ovf=%b done=%b busy=%b",
             name, A, B, F, Y, Y_hi, zero, carry, ovf, done, busy);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; F = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Y", 32'(Y), 32'h00);
    chk("rst_Y_hi", 32'(Y_hi), 32'h00);
    chk("rst_flags", {busy, done, zero, carry, ovf}, 5'b00000);
    rst_n = 1'b1;

    // First edge with reset released accepts the op
    issue(8'hFF, 8'h01, 4'b0010);
    show("add");
    chk("add_Y", 32'(Y), 32'h00);
    chk("add_flags", {busy, done, zero, carry, ovf}, 5'b01110);
    @(posedge clk); #1;
    chk("add_done_one_cycle", 32'(done), 32'd0);
    chk("add_Y_hold", 32'(Y), 32'h00);

    issue(8'h80, 8'h01, 4'b0110);
    show("sub1");
    chk("sub1_Y", 32'(Y), 32'h7F);
    chk("sub1_zco", {zero, carry, ovf}, 3'b011);
    // Back-to-back: accepted from DONE, done stays high
    issue(8'h01, 8'h02, 4'b0110);
    show("sub2");
    chk("sub2_Y", 32'(Y), 32'hFF);
    chk("sub2_zco", {zero, carry, ovf}, 3'b000);
    chk("sub2_done_b2b", 32'(done), 32'd1);

    issue(8'h05, 8'h05, 4'b0111);
    show("eq");
    chk("eq_Y", 32'(Y), 32'h01);
    issue(8'h05, 8'h05, 4'b0011);
    show("gt_equal");
    chk("gt_equal_Y", 32'(Y), 32'h00);
    chk("gt_equal_zero", 32'(zero), 32'd1);
    issue(8'h06, 8'h05, 4'b0011);
    show("gt");
    chk("gt_Y", 32'(Y), 32'h01);

    issue(8'h81, 8'h01, 4'b1001);
    show("shl");
    chk("shl_Y", 32'(Y), 32'h02);
    issue(8'h81, 8'h08, 4'b1010);
    show("shr8");
    chk("shr8_Y", 32'(Y), 32'h00);
    chk("shr8_zero", 32'(zero), 32'd1);
    issue(8'h81, 8'h01, 4'b1010);
    show("shr1");
    chk("shr1_Y", 32'(Y), 32'h40);

    issue(8'hF0, 8'h3C, 4'b0000);
    show("and");
    chk("and_Y", 32'(Y), 32'h30);
    issue(8'hF0, 8'h0C, 4'b0001);
    show("or");
    chk("or_Y", 32'(Y), 32'hFC);
    issue(8'hF0, 8'h30, 4'b0100);
    show("andn");
    chk("andn_Y", 32'(Y), 32'hC0);
    issue(8'h00, 8'hF0, 4'b0101);
    show("orn");
    chk("orn_Y", 32'(Y), 32'h0F);
    issue(8'hFF, 8'hFF, 4'b1111);
    show("reserved");
    chk("reserved_Y", 32'(Y), 32'h00);
    chk("reserved_zero", 32'(zero), 32'd1);

    // Leave a known nonzero result to prove it holds during EXEC
    issue(8'h12, 8'h34, 4'b0010);
    show("add2");
    chk("add2_Y", 32'(Y), 32'h46);

    issue(8'hFF, 8'hFF, 4'b1000);
    show("mul_start");
    chk("mul_busy_k", {busy, done}, 2'b10);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      if (i == 2) begin
        #1;
        A = 8'h02; B = 8'h03; F = 4'b0010; start = 1'b1;
      end else begin
        #1;
      end
      if (i == 4) start = 1'b0;
      chk($sformatf("mul_busy_%0d", i), {busy, done}, 2'b10);
      chk($sformatf("mul_hold_%0d", i), 32'(Y), 32'h46);
    end
    @(posedge clk); #1;
    show("mul_ffxff");
    chk("mul_Y", 32'(Y), 32'h01);
    chk("mul_Y_hi", 32'(Y_hi), 32'hFE);
    chk("mul_flags", {busy, done, zero, carry, ovf}, 5'b01000);
    @(posedge clk); #1;
    chk("mul_ignored_start", {busy, done}, 2'b00);
    chk("mul_Y_after", 32'(Y), 32'h01);

    issue(8'h10, 8'h10, 4'b1000);
    wait_done("mul2_done_seen");
    show("mul_10x10");
    chk("mul2_prod", {Y_hi, Y}, 16'h0100);
    chk("mul2_zero", 32'(zero), 32'd0);

    issue(8'h0C, 8'h0A, 4'b1000);
    wait_done("mul3_done_seen");
    show("mul_0cx0a");
    chk("mul3_prod", {Y_hi, Y}, 16'h0078);

    // Reset partway through a multiply
    issue(8'h12, 8'h34, 4'b1000);
    show("mul_abort_start");
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    show("mul_abort_reset");
    chk("abort_Y", 32'(Y), 32'h00);
    chk("abort_flags", {busy, done, zero, carry, ovf}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_done_%0d", i), {busy, done}, 2'b00);
    end

    issue(8'h7F, 8'h01, 4'b0010);
    show("add_post_reset");
    chk("add3_Y", 32'(Y), 32'h80);
    chk("add3_flags", {busy, done, zero, carry, ovf}, 5'b01001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
